// File: rtl/bus_arbiter.sv
// Round-robin arbiter: merges NumInitiators bus initiators onto one downstream request port.
// Optional busy timeout with error abort is enabled by defining BUS_ARBITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; pick the next requester after last_q, round-robin
// BUSY  | sel_q granted and its payload driven downstream; waiting for bus_ack_i
module bus_arbiter #(
  parameter int NumInitiators = 2,
  parameter int AddrWidth     = 30,
  parameter int TimeoutCycles = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumInitiators-1:0]       init_req_i,
  input  logic [NumInitiators-1:0]       init_we_i,
  input  logic [NumInitiators*AddrWidth-1:0] init_addr_i,
  input  logic [NumInitiators*32-1:0]    init_wdata_i,
  input  logic [NumInitiators*4-1:0]     init_be_i,
  output logic [NumInitiators-1:0]       init_ack_o,
  output logic [NumInitiators-1:0]       init_err_o,
  output logic [31:0]                    init_rdata_o,
  output logic [NumInitiators-1:0]       grant_o,
  output logic                           bus_req_o,
  output logic                           bus_we_o,
  output logic [AddrWidth-1:0]           bus_addr_o,
  output logic [31:0]                    bus_wdata_o,
  output logic [3:0]                     bus_be_o,
  input  logic                           bus_ack_i,
  input  logic [31:0]                    bus_rdata_i
);

  localparam int SelW = (NumInitiators > 1) ? $clog2(NumInitiators) : 1;
  localparam logic [SelW-1:0] LastInit = SelW'(NumInitiators - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                   state, state_next;
  logic [SelW-1:0]          sel_q, sel_next;
  logic [SelW-1:0]          last_q, last_next;
  logic [SelW-1:0]          pick;
  logic                     found;
  logic                     timeout;
  logic [NumInitiators-1:0] sel_onehot;

  if (NumInitiators < 2 || NumInitiators > 8 || TimeoutCycles < 2) begin : g_bad_params
    $error("bus_arbiter: unsupported parameter value");
  end

  assign sel_onehot   = {{(NumInitiators-1){1'b0}}, 1'b1} << sel_q;
  assign init_rdata_o = bus_rdata_i;

  // Scan upward from the initiator after the last one served, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NumInitiators; i++) begin
      if (!found && init_req_i[(int'(last_q) + 1 + i) % NumInitiators]) begin
        pick  = SelW'((int'(last_q) + 1 + i) % NumInitiators);
        found = 1'b1;
      end
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CntW = ($clog2(TimeoutCycles) > 8) ? $clog2(TimeoutCycles) : 8;
  logic [CntW-1:0] cnt_q;

  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

  // Held at zero in IDLE so the first BUSY cycle always starts from zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state == IDLE) begin
      cnt_q <= '0;
    end else if (!bus_ack_i && !timeout) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      sel_q  <= '0;
      last_q <= LastInit;
    end else begin
      state  <= state_next;
      sel_q  <= sel_next;
      last_q <= last_next;
    end
  end

  always_comb begin
    state_next  = state;
    sel_next    = sel_q;
    last_next   = last_q;
    init_ack_o  = '0;
    init_err_o  = '0;
    grant_o     = '0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_be_o    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          sel_next   = pick;
          state_next = BUSY;
        end
      end
      BUSY: begin
        grant_o     = sel_onehot;
        bus_req_o   = 1'b1;
        bus_we_o    = init_we_i[sel_q];
        bus_addr_o  = init_addr_i[int'(sel_q)*AddrWidth +: AddrWidth];
        bus_wdata_o = init_wdata_i[int'(sel_q)*32 +: 32];
        bus_be_o    = init_be_i[int'(sel_q)*4 +: 4];
        // An ack coinciding with the timeout wins: normal completion, no error.
        if (bus_ack_i) begin
          init_ack_o = sel_onehot;
          last_next  = sel_q;
          state_next = IDLE;
        end else if (timeout) begin
          init_err_o = sel_onehot;
          last_next  = sel_q;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
